// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters
// used by the receiver, transmitter and baud generator.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_PARITY_EN  = 0;
  localparam int UART_PARITY_ODD = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so idle-high lines do not glitch out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, validates the start bit, samples data,
// parity and stop at mid-bit on oversample ticks, and holds each word for the host.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = UART_PARITY_EN,
  parameter int PARITY_ODD = UART_PARITY_ODD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output rx_state_t            dbg_state
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_out_q, perr_out_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;
  logic                 load;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame sequencing only moves on tick cycles; everything holds otherwise.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d  = START;
            os_cnt_d = '0;
            perr_d   = 1'b0;
          end
        end
        START: begin
          if (os_cnt_q == OS_HALF) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (os_cnt_q == OS_LAST) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BC_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            perr_d   = (^shift_q) ^ rx_s ^ (PARITY_ODD != 0);
            os_cnt_d = '0;
            state_d  = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // valid/ready: a word transfers on any clk with data_valid && data_ready;
  // data_out and its flags hold unchanged until then.
  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = tick && (state_q == STOP) && (os_cnt_q == OS_LAST);
    load       = frame_done && (!valid_q || data_ready);
    data_d     = data_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    valid_d    = valid_q;
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d    = 1'b1;
      data_d     = shift_q;
      ferr_d     = ~rx_s;
      perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
    end
    overrun_d  = frame_done && !load;
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_out_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are built bit by bit from a byte-level
// model; received words are collected and compared against expected queues.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic rst_n, tick, line, sel_p, data_ready, data_ready_p;
  logic rx, rx_p;
  logic [7:0] data_out, data_out_p;
  logic data_valid, frame_err, parity_err, overrun, busy;
  logic data_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;
  rx_state_t dbg_state, dbg_state_p;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] got_p_q[$];
  logic [9:0] prev_word;
  int n_checks = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int valid_cycles = 0;
  bit busy_seen = 0;
  bit prev_hold = 0;
  bit rand_ready = 0;

  assign rx   = sel_p ? 1'b1 : line;
  assign rx_p = sel_p ? line : 1'b1;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .busy(busy), .dbg_state(dbg_state)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_p),
    .data_out(data_out_p), .data_valid(data_valid_p), .data_ready(data_ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p),
    .busy(busy_p), .dbg_state(dbg_state_p)
  );

  // Clock/reset and tick generation
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Monitor: collects transferred words and checks hold-while-valid
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (prev_hold) begin
        n_checks++;
        if (data_valid !== 1'b1 || {parity_err, frame_err, data_out} !== prev_word) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b word=%h required valid=1 word=%h",
                   data_valid, {parity_err, frame_err, data_out}, prev_word);
        end
      end
      prev_hold = data_valid && !data_ready;
      prev_word = {parity_err, frame_err, data_out};
      if (data_valid && data_ready) got_q.push_back({parity_err, frame_err, data_out});
      if (data_valid_p && data_ready_p) got_p_q.push_back({parity_err_p, frame_err_p, data_out_p});
      if (overrun) ovr_cnt++;
      if (data_valid) valid_cycles++;
      if (busy) busy_seen = 1'b1;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Reference model: status word {parity_err, frame_err, data} for one frame
  function automatic logic [9:0] model_word(input logic [7:0] d, input bit has_par,
                                            input bit par, input bit stop);
    logic perr;
    perr = has_par && ((^d) != par);
    return {perr, !stop, d};
  endfunction

  // Driver tasks
  task automatic hold_line(input logic v, input int n);
    line = v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rand_ready) data_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par,
                            input bit stop, input bit expect_word);
    hold_line(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT_CLK);
    if (has_par) hold_line(par, BIT_CLK);
    hold_line(stop, BIT_CLK);
    if (expect_word) exp_q.push_back(model_word(d, has_par, par, stop));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_p_q.delete();
    ovr_cnt = 0;
    valid_cycles = 0;
    busy_seen = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    line = 1'b1;
    sel_p = 1'b0;
    data_ready = 1'b1;
    data_ready_p = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h required 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b required 0", data_valid); end
    n_checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b required 00", frame_err, parity_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: busy=%b state=%0d required busy=0 state=%0d", busy, dbg_state, IDLE); end
    n_checks++; if (data_valid_p !== 1'b0 || busy_p !== 1'b0) begin n_fail++; $display("FAIL reset_parity_dut: valid=%b busy=%b required 0 0", data_valid_p, busy_p); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_sb();
    send_frame(8'hA5, 0, 0, 1, 1);
    hold_line(1'b1, BIT_CLK);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d words required 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL basic_word: got %h required %h", got_q[0], exp_q[0]); end
    end
    n_checks++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d clk required 1", valid_cycles); end
    n_checks++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL basic_overrun: got %0d required 0", ovr_cnt); end
  endtask

  task automatic test_false_start();
    clear_sb();
    hold_line(1'b0, 20);
    hold_line(1'b1, 2 * BIT_CLK);
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_rise: got %b required 1", busy_seen); end
    n_checks++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL false_start_no_valid: got %0d required 0", valid_cycles); end
    n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL false_start_idle: busy=%b state=%0d required busy=0 state=%0d", busy, dbg_state, IDLE); end
  endtask

  task automatic test_frame_err();
    clear_sb();
    send_frame(8'h3C, 0, 0, 0, 1);
    hold_line(1'b1, 2 * BIT_CLK);
    send_frame(8'h55, 0, 0, 1, 1);
    hold_line(1'b1, BIT_CLK);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL frame_err_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_err_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back_overrun();
    clear_sb();
    data_ready = 1'b0;
    send_frame(8'h11, 0, 0, 1, 1);
    send_frame(8'h22, 0, 0, 1, 0);
    hold_line(1'b1, BIT_CLK);
    n_checks++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt); end
    n_checks++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin n_fail++; $display("FAIL overrun_held: valid=%b data=%h required valid=1 data=11", data_valid, data_out); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL overrun_no_transfer: got %0d words required 0", got_q.size()); end
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL overrun_consume: got %0d words first %h required 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, exp_q[0]); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_valid_drop: got %b required 0", data_valid); end
  endtask

  task automatic test_parity();
    clear_sb();
    sel_p = 1'b1;
    send_frame(8'h07, 1, 1, 1, 1);
    hold_line(1'b1, BIT_CLK);
    send_frame(8'h07, 1, 0, 1, 1);
    hold_line(1'b1, BIT_CLK);
    sel_p = 1'b0;
    n_checks++; if (got_p_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL parity_count: got %0d words required %0d", got_p_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (got_p_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL parity_word%0d: got %h required %h", i, got_p_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL parity_other_dut_quiet: got %0d words required 0", got_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    clear_sb();
    d = 8'hFA;
    hold_line(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) hold_line(d[i], BIT_CLK);
    hold_line(d[3], BIT_CLK / 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL midreset_state: busy=%b state=%0d required busy=0 state=%0d", busy, dbg_state, IDLE); end
    n_checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: data=%h valid=%b required data=00 valid=0", data_out, data_valid); end
    n_checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got %b%b%b required 000", frame_err, parity_err, overrun); end
    hold_line(1'b1, BIT_CLK / 2 - 1 + 6 * BIT_CLK);
    n_checks++; if (valid_cycles !== 0 || got_q.size() !== 0) begin n_fail++; $display("FAIL midreset_no_partial: got %0d valid clk required 0", valid_cycles); end
    send_frame(8'hF0, 0, 0, 1, 1);
    hold_line(1'b1, BIT_CLK);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_next_frame: got %0d words first %h required 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, exp_q[0]); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit stop;
    int gap;
    clear_sb();
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(d, 0, 0, stop, 1);
      if (gap > 0) hold_line(1'b1, gap * BIT_CLK + $urandom_range(0, 7));
    end
    rand_ready = 1'b0;
    data_ready = 1'b1;
    hold_line(1'b1, 2 * BIT_CLK);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL random_overrun: got %0d required 0", ovr_cnt); end
  endtask

  // Watchdog
  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before tests completed");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back_overrun();
    test_parity();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
